// File: rtl/knight_attack_sprite_sequencer.sv
// Knight attack animation sequencer: frame-tick FSM (IDLE/ATK1-3/COOLDOWN) plus per-pixel sprite geometry.
// Outputs registered, 1 vga_clk after DrawX/DrawY or frame_tick; no backpressure, one request buffered.
module knight_attack_sprite_sequencer #(
  parameter int SPRITE_W        = 50,
  parameter int SPRITE_H        = 64,
  parameter int HOLD_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  KnightX,
  input  logic [9:0]  KnightY,
  input  logic        facing_left,
  input  logic        attack_req,
  output logic [11:0] rom_address,
  output logic [1:0]  frame_sel,
  output logic        in_sprite,
  output logic        attacking,
  output logic        attack_done
);

  localparam int MAX_F = (HOLD_FRAMES > COOLDOWN_FRAMES) ? HOLD_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W = $clog2(MAX_F + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ATK1, S_ATK2, S_ATK3, S_COOL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [9:0]       lx_q, lx_d, ly_q, ly_d;
  logic             lf_q, lf_d;
  logic [1:0]       frame_sel_q, frame_sel_d;
  logic             attacking_q, attacking_d;
  logic             attack_done_q, attack_done_d;
  logic [11:0]      rom_address_q, rom_address_d;
  logic             in_sprite_q, in_sprite_d;

  logic [10:0] dx, dy;
  logic [9:0]  col;
  logic        in_box;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          if (attack_req || pending_q) begin
            state_d   = S_ATK1;
            cnt_d     = '0;
            pending_d = 1'b0;
          end
        end else if (attack_req) begin
          pending_d = 1'b1;
        end
      end
      S_ATK1, S_ATK2, S_ATK3: begin
        if (attack_req) pending_d = 1'b1;
        if (frame_tick) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            case (state_q)
              S_ATK1:  state_d = S_ATK2;
              S_ATK2:  state_d = S_ATK3;
              default: state_d = S_COOL;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COOL: begin
        if (frame_tick && cnt_q == COOL_LAST) begin
          cnt_d = '0;
          // A buffered or same-tick request skips IDLE and re-attacks immediately.
          if (attack_req || pending_q) begin
            state_d   = S_ATK1;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (attack_req) pending_d = 1'b1;
          if (frame_tick) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    frame_sel_d = 2'd0;
    case (state_d)
      S_ATK1:  frame_sel_d = 2'd1;
      S_ATK2:  frame_sel_d = 2'd2;
      S_ATK3:  frame_sel_d = 2'd3;
      default: frame_sel_d = 2'd0;
    endcase
    attacking_d   = (frame_sel_d != 2'd0);
    attack_done_d = (state_q == S_ATK3) && (state_d == S_COOL);
  end

  // Position and facing only move on the frame tick so a sprite never tears mid-frame.
  always_comb begin
    lx_d = frame_tick ? KnightX     : lx_q;
    ly_d = frame_tick ? KnightY     : ly_q;
    lf_d = frame_tick ? facing_left : lf_q;
  end

  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, lx_q};
    dy     = {1'b0, DrawY} - {1'b0, ly_q};
    in_box = !dx[10] && !dy[10] &&
             (dx[9:0] < 10'(SPRITE_W)) && (dy[9:0] < 10'(SPRITE_H));
    col    = lf_q ? (10'(SPRITE_W - 1) - dx[9:0]) : dx[9:0];
    rom_address_d = in_box ? (12'(dy[9:0]) * 12'(SPRITE_W) + 12'(col)) : 12'd0;
    in_sprite_d   = in_box && attacking_q;
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      lx_q          <= '0;
      ly_q          <= '0;
      lf_q          <= 1'b0;
      frame_sel_q   <= 2'd0;
      attacking_q   <= 1'b0;
      attack_done_q <= 1'b0;
      rom_address_q <= '0;
      in_sprite_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      lx_q          <= lx_d;
      ly_q          <= ly_d;
      lf_q          <= lf_d;
      frame_sel_q   <= frame_sel_d;
      attacking_q   <= attacking_d;
      attack_done_q <= attack_done_d;
      rom_address_q <= rom_address_d;
      in_sprite_q   <= in_sprite_d;
    end
  end

  assign rom_address = rom_address_q;
  assign frame_sel   = frame_sel_q;
  assign in_sprite   = in_sprite_q;
  assign attacking   = attacking_q;
  assign attack_done = attack_done_q;

endmodule

// File: tb/tb_knight_attack_sprite_sequencer.sv
// Directed bench for knight_attack_sprite_sequencer with hand-computed expectations.
module tb_knight_attack_sprite_sequencer;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic [9:0]  DrawX, DrawY, KnightX, KnightY;
  logic        facing_left, attack_req;
  logic [11:0] rom_address;
  logic [1:0]  frame_sel;
  logic        in_sprite, attacking, attack_done;

  int checks = 0;
  int errors = 0;

  knight_attack_sprite_sequencer dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .KnightX     (KnightX),
    .KnightY     (KnightY),
    .facing_left (facing_left),
    .attack_req  (attack_req),
    .rom_address (rom_address),
    .frame_sel   (frame_sel),
    .in_sprite   (in_sprite),
    .attacking   (attacking),
    .attack_done (attack_done)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick();
      step();
    end
  endtask

  task automatic pulse_req();
    attack_req = 1'b1;
    step();
    attack_req = 1'b0;
  endtask

  task automatic pixel(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; attack_req = 1'b0; facing_left = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; KnightX = 10'd0; KnightY = 10'd0;
    #3;
    check_eq("rst_frame_sel", 32'(frame_sel), 0);
    check_eq("rst_attacking", 32'(attacking), 0);
    check_eq("rst_rom_address", 32'(rom_address), 0);
    check_eq("rst_in_sprite", 32'(in_sprite), 0);
    check_eq("rst_attack_done", 32'(attack_done), 0);
    step();
    Reset = 1'b0;
    step();

    // One-cycle request between ticks in IDLE must survive until the tick.
    KnightX = 10'd100; KnightY = 10'd200;
    pulse_req();
    step(); step();
    check_eq("idle_wait_frame_sel", 32'(frame_sel), 0);
    do_tick();
    check_eq("atk1_frame_sel", 32'(frame_sel), 1);
    check_eq("atk1_attacking", 32'(attacking), 1);

    pixel(100, 200);
    check_eq("geo_origin_addr", 32'(rom_address), 0);
    check_eq("geo_origin_in", 32'(in_sprite), 1);
    pixel(149, 263);
    check_eq("geo_corner_addr", 32'(rom_address), 3199);
    check_eq("geo_corner_in", 32'(in_sprite), 1);
    pixel(150, 263);
    check_eq("geo_right_out_in", 32'(in_sprite), 0);
    check_eq("geo_right_out_addr", 32'(rom_address), 0);

    ticks(3);
    check_eq("atk1_hold3_frame_sel", 32'(frame_sel), 1);
    facing_left = 1'b1;
    ticks(1);
    check_eq("atk2_frame_sel", 32'(frame_sel), 2);

    pixel(100, 200);
    check_eq("mirror_origin_addr", 32'(rom_address), 49);
    pixel(149, 200);
    check_eq("mirror_right_addr", 32'(rom_address), 0);
    KnightX = 10'd300;
    pixel(100, 200);
    check_eq("midframe_move_addr", 32'(rom_address), 49);
    check_eq("midframe_move_in", 32'(in_sprite), 1);
    KnightX = 10'd100;
    facing_left = 1'b0;

    ticks(4);
    check_eq("atk3_frame_sel", 32'(frame_sel), 3);
    ticks(3);
    check_eq("atk3_no_done_early", 32'(attack_done), 0);
    do_tick();
    check_eq("done_pulse", 32'(attack_done), 1);
    check_eq("cool_frame_sel", 32'(frame_sel), 0);
    check_eq("cool_attacking", 32'(attacking), 0);
    step();
    check_eq("done_pulse_clears", 32'(attack_done), 0);

    // Not attacking: address still generated, in_sprite suppressed.
    pixel(110, 201);
    check_eq("cool_geo_addr", 32'(rom_address), 60);
    check_eq("cool_geo_in", 32'(in_sprite), 0);

    ticks(8);
    check_eq("idle_after_cool", 32'(frame_sel), 0);
    ticks(2);
    check_eq("idle_stays", 32'(frame_sel), 0);

    // Request on the tick itself is consumed that tick.
    attack_req = 1'b1;
    do_tick();
    attack_req = 1'b0;
    check_eq("req_on_tick_frame_sel", 32'(frame_sel), 1);
    step();
    pulse_req();
    ticks(8);
    check_eq("pend_atk3", 32'(frame_sel), 3);
    pulse_req();
    ticks(4);
    check_eq("pend_cool", 32'(frame_sel), 0);
    ticks(7);
    check_eq("pend_cool_7", 32'(frame_sel), 0);
    ticks(1);
    check_eq("reattack_frame_sel", 32'(frame_sel), 1);
    ticks(12);
    check_eq("reattack_cool", 32'(frame_sel), 0);
    ticks(8);
    check_eq("second_req_dropped", 32'(frame_sel), 0);
    ticks(1);
    check_eq("second_req_dropped_2", 32'(frame_sel), 0);

    // Clipping at the bottom-right of the screen.
    KnightX = 10'd620; KnightY = 10'd450;
    attack_req = 1'b1;
    do_tick();
    attack_req = 1'b0;
    pixel(639, 479);
    check_eq("clip_addr", 32'(rom_address), 1469);
    check_eq("clip_in", 32'(in_sprite), 1);
    pixel(0, 479);
    check_eq("clip_nowrap_in", 32'(in_sprite), 0);
    check_eq("clip_nowrap_addr", 32'(rom_address), 0);

    // Reset in ATK2 with a request buffered.
    ticks(4);
    check_eq("pre_rst_atk2", 32'(frame_sel), 2);
    pulse_req();
    pixel(625, 455);
    Reset = 1'b1;
    step();
    check_eq("midrst_frame_sel", 32'(frame_sel), 0);
    check_eq("midrst_attacking", 32'(attacking), 0);
    check_eq("midrst_addr", 32'(rom_address), 0);
    Reset = 1'b0;
    step();
    ticks(3);
    check_eq("post_rst_no_attack", 32'(frame_sel), 0);
    check_eq("post_rst_no_attacking", 32'(attacking), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/knight_attack_sprite_sequencer.md
Name: knight_attack_sprite_sequencer

Overview:
Upstream companion to the per-frame sprite ROM/palette stages for the knight attack animation. It sequences the three attack frames (attack1/2/3) on a frame-tick timebase, latches the knight position and facing once per video frame, and computes a registered, sprite-relative ROM address with horizontal mirroring for each DrawX/DrawY. Its outputs drive the selected attack ROM's address and the in-sprite mux in the colour mapper.

Parameters:
SPRITE_W, 50, sprite width in pixels
SPRITE_H, 64, sprite height in pixels
HOLD_FRAMES, 4, video frames each attack sprite is displayed (>=1)
COOLDOWN_FRAMES, 8, idle frames after attack3 before a new attack may start (>=1)

Ports:
vga_clk  input  1  pixel clock; all state on posedge
Reset  input  1  asynchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame (vga_clk domain, asserted at vsync start)
DrawX  input  10  current pixel column
DrawY  input  10  current pixel row
KnightX  input  10  sprite top-left column (live)
KnightY  input  10  sprite top-left row (live)
facing_left  input  1  1 = mirror horizontally (live)
attack_req  input  1  level or pulse; request an attack
rom_address  output  12  row*SPRITE_W + col into the selected attack ROM
frame_sel  output  2  0=none, 1=attack1, 2=attack2, 3=attack3
in_sprite  output  1  current pixel lies inside the sprite box while attacking
attacking  output  1  FSM in ATK1/ATK2/ATK3
attack_done  output  1  one-cycle pulse on the ATK3->COOLDOWN transition

Behaviour:
- Reset (async, active-high): FSM=IDLE, hold_cnt=0, pending=0, latched X/Y/facing=0. Outputs: rom_address=0, frame_sel=0, in_sprite=0, attacking=0, attack_done=0.
- Latching: on a cycle with frame_tick=1, capture KnightX/KnightY/facing_left into lx/ly/lf. Geometry never changes mid-frame.
- FSM states: IDLE, ATK1, ATK2, ATK3, COOLDOWN. All transitions occur only on a frame_tick cycle.
  - IDLE: on frame_tick with (attack_req|pending) -> ATK1, hold_cnt=0, pending=0.
  - ATKn: on each frame_tick, hold_cnt++. When hold_cnt==HOLD_FRAMES-1 at a tick: go to the next state and reset hold_cnt. ATK3 goes to COOLDOWN and pulses attack_done for that cycle.
  - COOLDOWN: counts COOLDOWN_FRAMES ticks, then goes to IDLE. If pending is set, it goes directly to ATK1 instead.
- Request buffering: attack_req seen in any non-IDLE state sets pending (a single-deep buffer; extra requests are dropped). attack_req in IDLE between ticks also sets pending, so a 1-cycle pulse is never lost. On a tick, the transition consumes pending.
- frame_sel = 1/2/3 in ATK1/2/3, else 0. attacking = (frame_sel!=0). Both are registered and change the cycle after the tick.
- Geometry, computed each cycle and registered (1-cycle latency from DrawX/DrawY):
  - dx = DrawX - lx, dy = DrawY - ly, evaluated in 11-bit signed arithmetic.
  - in_box = 0<=dx<SPRITE_W and 0<=dy<SPRITE_H.
  - col = lf ? SPRITE_W-1-dx : dx.
  - rom_address = in_box ? dy*SPRITE_W + col : 0, truncated to 12 bits. Maximum value is 3199 for the defaults.
  - in_sprite = in_box & attacking. Uses the attacking value in effect during the compute cycle.
- Address timing: rom_address is valid by the following negedge, which the downstream ROM read uses. RGB then appears at the next posedge, so total pixel latency is 2 posedges from DrawX/DrawY.
- Boundaries:
  - lx+SPRITE_W>639 or ly+SPRITE_H>479: box is clipped naturally; no wrap into column 0.
  - frame_tick coinciding with attack_req: the request is consumed that tick.
  - Reset mid-attack: immediate IDLE; pending is cleared.

Test Plan:
- Reset during ATK2 -> next cycle frame_sel=0, attacking=0, rom_address=0. After release, no attack occurs without a new request.
- lx=100, ly=200, lf=0, attacking; DrawX=100,DrawY=200 -> rom_address=0, in_sprite=1 one cycle later. DrawX=149,DrawY=263 -> 3199. DrawX=150 -> in_sprite=0, rom_address=0.
- Same position with lf=1: DrawX=100,DrawY=200 -> rom_address=49. DrawX=149 -> 0. KnightX changed mid-frame -> no effect until the next frame_tick.
- 1-cycle attack_req pulse in IDLE between ticks, HOLD_FRAMES=4:
  - frame_sel goes 1 after the next tick, then 2 after 4 more ticks, then 3 after 4 more.
  - attack_done pulses once on the 4th tick in ATK3.
- attack_req during ATK1 plus a second request in ATK3, COOLDOWN_FRAMES=8 -> after ATK3, exactly one re-attack starts at the end of cooldown (ATK1 after 8 ticks). The second request is dropped.
- lx=620, ly=450 -> DrawX=639,DrawY=479 gives rom_address=29*50+19=1469, in_sprite=1. DrawX=0 -> in_sprite=0 (no wrap).
